// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared state encoding, sizes and grant helper for the arbiter
package mux_rr_arbiter_pkg;
   localparam int NREQ  = 4;
   localparam int SEL_W = 2;
   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// mux_rr_arbiter_rr_pick: combinational round-robin pick starting just after ptr
module mux_rr_arbiter_rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic [NREQ-1:0]  mask,
   output logic             hit,
   output logic [SEL_W-1:0] idx
);
   logic [NREQ-1:0]  w_m;
   logic [NREQ-1:0]  w_rot;
   logic [SEL_W-1:0] w_enc;
   assign w_m = req & mask;
   // rotate so ptr+1 lands at bit 0, take the lowest set bit, rotate the index back
   always_comb begin
      w_rot = '0;
      w_enc = '0;
      hit   = |w_m;
      for (int i = 0; i < NREQ; i++) w_rot[i] = w_m[SEL_W'(ptr + SEL_W'(i) + 1'b1)];
      for (int i = NREQ - 1; i >= 0; i--) if (w_rot[i]) w_enc = SEL_W'(i);
      idx = SEL_W'(w_enc + ptr + 1'b1);
   end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 4:1 selector; optional ARB_TIMEOUT_EN pre-emption
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int DATA_W  = 1,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] W,
   output logic [NREQ-1:0]        gnt,
   output logic [SEL_W-1:0]       sel,
   output logic                   valid,
   output logic [DATA_W-1:0]      f
);
   state_t           r_state, w_state_nx;
   logic [NREQ-1:0]  r_gnt, w_gnt_nx;
   logic [SEL_W-1:0] r_sel, w_sel_nx;
   logic [SEL_W-1:0] r_ptr, w_ptr_nx;
   logic             w_hit, w_take, w_tmo;
   logic [SEL_W-1:0] w_idx;
   logic [DATA_W-1:0] w_words [NREQ];
   logic [DATA_W-1:0] w_f;

   // the current owner is masked out so a pre-emption never re-picks it
   mux_rr_arbiter_rr_pick u_pick (
      .req  (req),
      .ptr  (r_ptr),
      .mask (~r_gnt),
      .hit  (w_hit),
      .idx  (w_idx)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] r_cnt;
   assign w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);
   // tenure counter: clears on every new grant, saturates while nobody else waits
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= (w_take || r_state == ST_IDLE) ? '0 : (w_tmo ? r_cnt : r_cnt + 1'b1);
`else
   assign w_tmo = 1'b0;
`endif

   // next grant: new pick from idle, on release, or on tenure expiry
   always_comb begin
      w_state_nx = r_state;
      w_gnt_nx   = r_gnt;
      w_sel_nx   = r_sel;
      w_ptr_nx   = r_ptr;
      w_take     = 1'b0;
      if (r_state == ST_IDLE) w_take = w_hit;
      else if (!req[r_sel]) begin
         w_take = w_hit;
         if (!w_hit) begin
            w_state_nx = ST_IDLE;
            w_gnt_nx   = '0;
         end
      end else w_take = w_tmo & w_hit;
      if (w_take) begin
         w_state_nx = ST_GRANT;
         w_gnt_nx   = onehot(w_idx);
         w_sel_nx   = w_idx;
         w_ptr_nx   = w_idx;
      end
   end

   // state and grant registers; ptr=3 on reset so the first search starts at 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_ptr   <= SEL_W'(NREQ - 1);
      end else begin
         r_state <= w_state_nx;
         r_gnt   <= w_gnt_nx;
         r_sel   <= w_sel_nx;
         r_ptr   <= w_ptr_nx;
      end

   for (genvar i = 0; i < NREQ; i++) begin : g_word
      assign w_words[i] = W[i*DATA_W +: DATA_W];
   end
   for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      assign w_f[b] = w_words[r_sel][b];
   end

   assign gnt   = r_gnt;
   assign sel   = r_sel;
   assign valid = |r_gnt;
   assign f     = valid ? w_f : '0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed checks of grant order, release, idle, reset and (optionally) timeout
module tb_mux_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] W = 16'hDCBA;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        valid;
   logic [3:0]  f;
   int total = 0;
   int bad = 0;

   mux_rr_arbiter #(.DATA_W(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .W(W),
      .gnt(gnt), .sel(sel), .valid(valid), .f(f)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_gnt(input string name, input logic [3:0] exp_g);
      total++;
      if (gnt !== exp_g) begin
         bad++;
         $display("FAIL %s gnt got=%b want=%b", name, gnt, exp_g);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({gnt, sel, valid, f} !== 11'b0) begin
         bad++;
         $display("FAIL reset_state got gnt=%b sel=%0d valid=%b f=%h want all 0", gnt, sel, valid, f);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      tick();
      chk_gnt("single_first", 4'b0001);
      total++;
      if (sel !== 2'd0 || valid !== 1'b1 || f !== 4'hA) begin
         bad++;
         $display("FAIL single_out got sel=%0d valid=%b f=%h want 0 1 a", sel, valid, f);
      end
      for (int i = 0; i < 4; i++) tick();
      chk_gnt("single_hold", 4'b0001);
      W = 16'hDCB5;
      #1;
      total++;
      if (f !== 4'h5) begin
         bad++;
         $display("FAIL single_f_track got=%h want=5", f);
      end
      W = 16'hDCBA;
   endtask

   task automatic test_pair();
      do_reset();
      req = 4'b1010;
      tick();
      chk_gnt("pair_first", 4'b0010);
      req = 4'b1000;
      tick();
      chk_gnt("pair_handover", 4'b1000);
      total++;
      if (sel !== 2'd3 || f !== 4'hD) begin
         bad++;
         $display("FAIL pair_sel got sel=%0d f=%h want 3 d", sel, f);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_q [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111;
      tick();
      chk_gnt("rot_start", exp_q[0]);
      for (int k = 0; k < 4; k++) begin
         req = 4'b1111 & ~exp_q[k];
         tick();
         chk_gnt("rot_next", exp_q[k+1]);
         total++;
         if ($countones(gnt) > 1) begin
            bad++;
            $display("FAIL rot_multihot got=%b want onehot", gnt);
         end
         req = 4'b1111;
         tick();
         chk_gnt("rot_hold", exp_q[k+1]);
      end
   endtask

   task automatic test_idle();
      do_reset();
      req = 4'b0100;
      tick();
      chk_gnt("idle_first", 4'b0100);
      req = 4'b0000;
      tick();
      chk_gnt("idle_drop", 4'b0000);
      total++;
      if (valid !== 1'b0 || f !== 4'h0) begin
         bad++;
         $display("FAIL idle_out got valid=%b f=%h want 0 0", valid, f);
      end
      req = 4'b0100;
      tick();
      chk_gnt("idle_regrant", 4'b0100);
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b1000;
      tick();
      req = 4'b0100;
      tick();
      chk_gnt("ar_pre", 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0 || sel !== 2'd0 || valid !== 1'b0 || f !== 4'h0) begin
         bad++;
         $display("FAIL ar_immediate got gnt=%b sel=%0d valid=%b f=%h want 0", gnt, sel, valid, f);
      end
      req = 4'b1100;
      #1 rst_n = 1'b1;
      tick();
      chk_gnt("ar_restart", 4'b0100);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk_gnt("tmo_alt", (((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk_gnt("tmo_solo", 4'b0001);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_pair();
      test_rotation();
      test_idle();
      test_async_reset();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
